// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Request/response bundle for one requester port of dmem_arbiter.
//
// Signals:
//   req      requester -> arbiter  request; held with fields stable until gnt
//   we       requester -> arbiter  1 = store, 0 = load
//   addr     requester -> arbiter  byte address
//   wdata    requester -> arbiter  store data, right-aligned
//   dm_ctrl  requester -> arbiter  000 B, 001 H, 010 W, 100 BU, 101 HU
//   gnt      arbiter -> requester  one-cycle pulse, request accepted
//   rvalid   arbiter -> requester  one-cycle pulse, response valid
//   rdata    arbiter -> requester  load result, held until the next response
//   err      arbiter -> requester  qualified by rvalid, access rejected
//
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  dm_ctrl;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata, dm_ctrl,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, dm_ctrl,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-port arbiter and access sequencer in front of data_memory. Port 0 is the
// core load/store port, port 1 the debug/loader port. Requests are serialised
// through a registered IDLE -> ACCESS -> RESP sequence; misaligned,
// out-of-range and undefined accesses are rejected before reaching memory.
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   rst            synchronous active-high reset
//   p0, p1         dmem_arbiter_if.slave requester ports
//   mem_addr_o     address to data_memory (0 outside ACCESS)
//   mem_wdata_o    store data to data_memory (0 outside ACCESS)
//   mem_we_o       write enable to data_memory, forced low while rst is high
//   mem_dm_ctrl_o  size/sign control to data_memory (0 outside ACCESS)
//   mem_rdata_i    combinational read data from data_memory
//
// Parameters:
//   DEPTH_WORDS    number of 32-bit words; legal byte addresses 0..DEPTH_WORDS*4-1
//
// Build option:
//   DMEM_ARB_ROUND_ROBIN_EN  defined   -> round-robin between simultaneous
//                                         requests, port 0 first after reset
//                            undefined -> fixed priority, port 0 always wins
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DEPTH_WORDS = 32
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  p0,
  dmem_arbiter_if.slave  p1,
  output logic [31:0]    mem_addr_o,
  output logic [31:0]    mem_wdata_o,
  output logic           mem_we_o,
  output logic [2:0]     mem_dm_ctrl_o,
  input  logic [31:0]    mem_rdata_i
);

  // One bit wider than the address so DEPTH_WORDS*4 = 2^32 still compares right.
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Any single condition below rejects the access.
  function automatic logic access_err(input logic        we,
                                      input logic [31:0] addr,
                                      input logic [2:0]  ctrl);
    logic e;
    e = 1'b0;
    case (ctrl)
      3'b000, 3'b100: e = 1'b0;
      3'b001, 3'b101: e = addr[0];
      3'b010:         e = (addr[1:0] != 2'b00);
      default:        e = 1'b1;
    endcase
    // Sign/zero extension only makes sense for loads.
    if (we && ctrl[2]) e = 1'b1;
    if ({1'b0, addr} >= ADDR_LIMIT) e = 1'b1;
    return e;
  endfunction

  state_t      state_q;
  logic        last_q;
  logic        port_q;
  logic        we_q;
  logic        err_q;

  logic        gnt0_q, gnt1_q;
  logic        rvalid0_q, rvalid1_q;
  logic        err0_q, err1_q;
  logic [31:0] rdata0_q, rdata1_q;

  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        mem_we_q;
  logic [2:0]  mem_ctrl_q;

  logic        any_req;
  logic        win_d;
  logic        last_d;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_ctrl;
  logic        sel_err;
  logic [31:0] resp_data;

  // Arbitration and selection of the winning request's fields.
  always_comb begin
    any_req = p0.req | p1.req;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // On a tie, hand the slot to the port that was not granted last.
    win_d = p1.req & (~p0.req | ~last_q);
`else
    win_d = ~p0.req;
`endif
    last_d    = any_req ? win_d : last_q;
    sel_we    = win_d ? p1.we      : p0.we;
    sel_addr  = win_d ? p1.addr    : p0.addr;
    sel_wdata = win_d ? p1.wdata   : p0.wdata;
    sel_ctrl  = win_d ? p1.dm_ctrl : p0.dm_ctrl;
    sel_err   = access_err(sel_we, sel_addr, sel_ctrl);
    // Rejected accesses and stores return zero.
    resp_data = (err_q | we_q) ? 32'h0 : mem_rdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= 32'h0;
      rdata1_q    <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_we_q    <= 1'b0;
      mem_ctrl_q  <= 3'b000;
    end else begin
      // Pulses and the memory bus default low; only the active state raises them.
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_we_q    <= 1'b0;
      mem_ctrl_q  <= 3'b000;

      case (state_q)
        S_IDLE, S_RESP: begin
          if (any_req) begin
            state_q     <= S_ACCESS;
            port_q      <= win_d;
            last_q      <= last_d;
            we_q        <= sel_we;
            err_q       <= sel_err;
            gnt0_q      <= ~win_d;
            gnt1_q      <= win_d;
            // The memory bus is loaded here so it is registered during ACCESS.
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_we_q    <= sel_we & ~sel_err;
            mem_ctrl_q  <= sel_ctrl;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_ACCESS: begin
          state_q <= S_RESP;
          if (port_q) begin
            rvalid1_q <= 1'b1;
            err1_q    <= err_q;
            rdata1_q  <= resp_data;
          end else begin
            rvalid0_q <= 1'b1;
            err0_q    <= err_q;
            rdata0_q  <= resp_data;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign p0.gnt    = gnt0_q;
  assign p1.gnt    = gnt1_q;
  assign p0.rvalid = rvalid0_q;
  assign p1.rvalid = rvalid1_q;
  assign p0.err    = err0_q;
  assign p1.err    = err1_q;
  assign p0.rdata  = rdata0_q;
  assign p1.rdata  = rdata1_q;

  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign mem_dm_ctrl_o = mem_ctrl_q;
  // A reset arriving during ACCESS must abort the store in that same cycle.
  assign mem_we_o      = mem_we_q & ~rst;

endmodule
